// File: rtl/frontend_command_definition_pkg.sv
// Frontend command definition shared by the frontend arbiter and its controller.
// Holds the command payload, opcodes and the arbiter default sizing.
package frontend_command_definition_pkg;

    localparam int unsigned DQ_BITS   = 8;
    localparam int unsigned DATA_BITS = DQ_BITS * 8;
    localparam int unsigned BANK_BITS = 3;
    localparam int unsigned ROW_BITS  = 14;
    localparam int unsigned COL_BITS  = 10;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } frontend_op_t;

    typedef struct packed {
        frontend_op_t          op;
        logic [BANK_BITS-1:0]  bank;
        logic [ROW_BITS-1:0]   row_addr;
        logic [COL_BITS-1:0]   col_addr;
    } frontend_command_t;

    localparam int unsigned FRONTEND_CMD_BITS = $bits(frontend_command_t);

    localparam int unsigned ARB_NUM_REQ      = 2;
    localparam int unsigned ARB_TAG_DEPTH    = 8;
    localparam int unsigned ARB_STARVE_LIMIT = 4;

    // Index width that stays at least one bit for single-entry ranges
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frontend_cmd_arbiter_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding read, in issue order.
module arb_tag_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             power_on_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/frontend_cmd_arbiter.sv
// Arbitrates frontend requesters into one registered controller command slot,
// favouring row hits with bounded starvation, and routes read data back by tag.
module frontend_cmd_arbiter
    import frontend_command_definition_pkg::*;
#(
    parameter int unsigned NUM_REQ      = ARB_NUM_REQ,
    parameter int unsigned TAG_DEPTH    = ARB_TAG_DEPTH,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                              clk,
    input  logic                              power_on_rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  frontend_command_t [NUM_REQ-1:0]   req_cmd,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              ctl_valid,
    output frontend_command_t                 ctl_cmd,
    output logic [DATA_BITS-1:0]              ctl_wdata,
    input  logic                              ctl_ready,
    input  logic [DATA_BITS-1:0]              ctl_rdata,
    input  logic                              ctl_rdata_valid,
    output logic                              ctl_ren,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_BITS-1:0]              rsp_data,
    input  logic [NUM_REQ-1:0]                rsp_ready,
    output logic                              err_orphan
);

    localparam int unsigned IDX_W    = idx_bits(NUM_REQ);
    localparam int unsigned ROT_W    = IDX_W + 1;
    localparam int unsigned CNT_W    = $clog2(TAG_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  hit;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    rr_win;
    logic [IDX_W-1:0]    hit_win;
    logic [IDX_W-1:0]    grant;
    logic [ROT_W-1:0]    rot;
    logic                rr_found;
    logic                hit_found;
    logic                use_hit;
    logic                slot_load;
    logic                load;
    logic [STARVE_W-1:0] starve_cnt;
    logic                last_row_valid;
    logic [ROW_BITS-1:0] last_row;
    logic                tag_push;
    logic                tag_pop;
    logic                tag_empty;
    logic                tag_full;
    logic [IDX_W-1:0]    tag_head;
    logic [CNT_W-1:0]    tag_count;

    // Reads are held off while every tag is in flight
    always_comb begin
        eligible = '0;
        hit      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            eligible[k] = req_valid[k] && !((req_cmd[k].op == OP_READ) && tag_full);
            hit[k]      = eligible[k] && last_row_valid && (req_cmd[k].row_addr == last_row);
        end
    end

    // First eligible and first row-hit requester, scanning from the RR pointer
    always_comb begin
        rr_found  = 1'b0;
        rr_win    = '0;
        hit_found = 1'b0;
        hit_win   = '0;
        rot       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rot = {1'b0, rr_ptr} + ROT_W'(i);
            if (rot >= ROT_W'(NUM_REQ)) rot = rot - ROT_W'(NUM_REQ);
            if (eligible[rot[IDX_W-1:0]] && !rr_found) begin
                rr_found = 1'b1;
                rr_win   = rot[IDX_W-1:0];
            end
            if (hit[rot[IDX_W-1:0]] && !hit_found) begin
                hit_found = 1'b1;
                hit_win   = rot[IDX_W-1:0];
            end
        end
    end

    assign slot_load = !ctl_valid || ctl_ready;
    assign use_hit   = hit_found && (starve_cnt != STARVE_W'(STARVE_LIMIT));
    assign grant     = use_hit ? hit_win : rr_win;
    assign load      = slot_load && rr_found && power_on_rst_n;
    assign req_ready = load ? (NUM_REQ'(1) << grant) : '0;

    assign tag_full  = (tag_count == CNT_W'(TAG_DEPTH));
    assign tag_push  = load && (req_cmd[grant].op == OP_READ);
    assign tag_pop   = ctl_rdata_valid && !tag_empty;
    assign ctl_ren   = !tag_empty && rsp_ready[tag_head];
    assign rsp_valid = tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
    assign rsp_data  = ctl_rdata;

    // Output slot, arbitration history and orphan flag
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            ctl_valid      <= 1'b0;
            ctl_cmd        <= '0;
            ctl_wdata      <= '0;
            rr_ptr         <= '0;
            starve_cnt     <= '0;
            last_row_valid <= 1'b0;
            last_row       <= '0;
            err_orphan     <= 1'b0;
        end else begin
            if (slot_load) ctl_valid <= rr_found;
            if (load) begin
                ctl_cmd        <= req_cmd[grant];
                ctl_wdata      <= req_wdata[grant];
                last_row       <= req_cmd[grant].row_addr;
                last_row_valid <= 1'b1;
                rr_ptr         <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
                starve_cnt     <= (use_hit && (hit_win != rr_win)) ? starve_cnt + STARVE_W'(1) : '0;
            end
            if (ctl_rdata_valid && tag_empty) err_orphan <= 1'b1;
        end
    end

    arb_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk            (clk),
        .power_on_rst_n (power_on_rst_n),
        .push           (tag_push),
        .push_data      (grant),
        .pop            (tag_pop),
        .head           (tag_head),
        .empty          (tag_empty),
        .count          (tag_count)
    );

endmodule

// File: tb/tb_frontend_cmd_arbiter.sv
// Bench for frontend_cmd_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_frontend_cmd_arbiter;
    import frontend_command_definition_pkg::*;

    localparam int unsigned NR = ARB_NUM_REQ;
    localparam int unsigned TD = ARB_TAG_DEPTH;
    localparam int unsigned SL = ARB_STARVE_LIMIT;

    logic                         clk = 1'b0;
    logic                         power_on_rst_n = 1'b1;
    logic [NR-1:0]                req_valid;
    frontend_command_t [NR-1:0]   req_cmd;
    logic [NR-1:0][DATA_BITS-1:0] req_wdata;
    logic [NR-1:0]                req_ready;
    logic                         ctl_valid;
    frontend_command_t            ctl_cmd;
    logic [DATA_BITS-1:0]         ctl_wdata;
    logic                         ctl_ready;
    logic [DATA_BITS-1:0]         ctl_rdata;
    logic                         ctl_rdata_valid;
    logic                         ctl_ren;
    logic [NR-1:0]                rsp_valid;
    logic [DATA_BITS-1:0]         rsp_data;
    logic [NR-1:0]                rsp_ready;
    logic                         err_orphan;

    frontend_cmd_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .power_on_rst_n(power_on_rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_wdata(req_wdata), .req_ready(req_ready),
        .ctl_valid(ctl_valid), .ctl_cmd(ctl_cmd), .ctl_wdata(ctl_wdata), .ctl_ready(ctl_ready),
        .ctl_rdata(ctl_rdata), .ctl_rdata_valid(ctl_rdata_valid), .ctl_ren(ctl_ren),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: slot contents, arbitration history, tag queue
    logic                 m_valid;
    frontend_command_t    m_cmd;
    logic [DATA_BITS-1:0] m_wdata;
    int                   m_rr;
    int                   m_starve;
    logic                 m_row_ok;
    int                   m_row;
    logic                 m_err;
    int                   tagq[$];

    int                   dut_grant;
    int                   next_row;
    frontend_command_t    last_cmd;
    logic [DATA_BITS-1:0] last_wd;
    int                   seq[3] = '{0, 1, 0};
    logic [63:0]          dat[3] = '{64'hA, 64'hB, 64'hC};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_cmd = '0; m_wdata = '0;
        m_rr = 0; m_starve = 0; m_row_ok = 1'b0; m_row = 0; m_err = 1'b0;
        tagq.delete();
    endtask

    task automatic set_req(input int k, input logic v, input frontend_op_t op, input int row);
        req_valid[k]          = v;
        req_cmd[k].op         = op;
        req_cmd[k].bank       = BANK_BITS'($urandom);
        req_cmd[k].row_addr   = ROW_BITS'(row);
        req_cmd[k].col_addr   = COL_BITS'($urandom);
        req_wdata[k]          = DATA_BITS'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        power_on_rst_n  = 1'b0;
        req_valid       = '0;
        ctl_ready       = 1'b0;
        ctl_rdata_valid = 1'b0;
        ctl_rdata       = '0;
        rsp_ready       = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ctl_valid", 64'(ctl_valid), 64'(0));
        check("rst_ctl_cmd",   64'(ctl_cmd),   64'(0));
        check("rst_ctl_wdata", 64'(ctl_wdata), 64'(0));
        check("rst_ctl_ren",   64'(ctl_ren),   64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_err",       64'(err_orphan), 64'(0));
        power_on_rst_n = 1'b1;
    endtask

    // One clock: compare outputs against the model, then advance model and DUT
    task automatic cycle();
        int rr_w, hit_w, g;
        logic [NR-1:0] elig, exp_rdy, exp_rspv;
        logic loadable, exp_ren;
        #1;
        rr_w = -1; hit_w = -1;
        for (int k = 0; k < int'(NR); k++)
            elig[k] = req_valid[k] && !(req_cmd[k].op == OP_READ && tagq.size() == int'(TD));
        for (int off = 0; off < int'(NR); off++) begin
            int k;
            k = (m_rr + off) % int'(NR);
            if (elig[k] && rr_w < 0) rr_w = k;
            if (elig[k] && m_row_ok && int'(req_cmd[k].row_addr) == m_row && hit_w < 0) hit_w = k;
        end
        loadable = !m_valid || ctl_ready;
        g = (hit_w >= 0 && m_starve < int'(SL)) ? hit_w : rr_w;
        exp_rdy = '0;
        if (g >= 0 && loadable) exp_rdy[g] = 1'b1;
        exp_ren = (tagq.size() > 0) && rsp_ready[tagq[0]];
        exp_rspv = '0;
        if (tagq.size() > 0 && ctl_rdata_valid) exp_rspv[tagq[0]] = 1'b1;

        check("req_ready",  64'(req_ready),  64'(exp_rdy));
        check("ctl_valid",  64'(ctl_valid),  64'(m_valid));
        check("ctl_cmd",    64'(ctl_cmd),    64'(m_cmd));
        check("ctl_wdata",  64'(ctl_wdata),  64'(m_wdata));
        check("ctl_ren",    64'(ctl_ren),    64'(exp_ren));
        check("rsp_valid",  64'(rsp_valid),  64'(exp_rspv));
        check("rsp_data",   64'(rsp_data),   64'(ctl_rdata));
        check("err_orphan", 64'(err_orphan), 64'(m_err));

        dut_grant = -1;
        for (int k = 0; k < int'(NR); k++) if (req_ready[k]) dut_grant = k;

        if (ctl_rdata_valid) begin
            if (tagq.size() > 0) void'(tagq.pop_front());
            else m_err = 1'b1;
        end
        if (loadable) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_cmd   = req_cmd[g];
                m_wdata = req_wdata[g];
                if (req_cmd[g].op == OP_READ) tagq.push_back(g);
                m_starve = (hit_w >= 0 && m_starve < int'(SL) && g != rr_w) ? m_starve + 1 : 0;
                m_rr     = (g + 1) % int'(NR);
                m_row_ok = 1'b1;
                m_row    = int'(req_cmd[g].row_addr);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        req_cmd = '0;
        req_wdata = '0;

        // Alternating writes to fresh rows
        do_reset();
        ctl_ready = 1'b1; rsp_ready = '1; next_row = 100;
        set_req(0, 1'b1, OP_WRITE, next_row); next_row++;
        set_req(1, 1'b1, OP_WRITE, next_row); next_row++;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("t1_grant%0d", i), 64'(dut_grant), 64'(i % 2));
            check($sformatf("t1_valid%0d", i), 64'(ctl_valid), 64'(1));
            if (dut_grant >= 0) begin
                last_cmd = req_cmd[dut_grant];
                last_wd  = req_wdata[dut_grant];
                set_req(dut_grant, 1'b1, OP_WRITE, next_row); next_row++;
            end
        end

        // Controller stall holds the slot
        ctl_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_ready", 64'(req_ready), 64'(0));
            check("t2_cmd",   64'(ctl_cmd),   64'(last_cmd));
            check("t2_wdata", 64'(ctl_wdata), 64'(last_wd));
        end

        // Row-hit streaming bounded by the starvation limit
        do_reset();
        ctl_ready = 1'b1;
        set_req(1, 1'b1, OP_WRITE, 3);
        cycle();
        check("t3_first", 64'(dut_grant), 64'(1));
        set_req(1, 1'b1, OP_WRITE, 3);
        set_req(0, 1'b1, OP_WRITE, 7);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("t3_grant%0d", i), 64'(dut_grant), 64'((i < 4) ? 1 : 0));
            if (dut_grant >= 0) set_req(dut_grant, 1'b1, OP_WRITE, (dut_grant == 1) ? 3 : 7);
        end

        // Tag exhaustion blocks reads but not writes
        do_reset();
        ctl_ready = 1'b1; rsp_ready = '0;
        begin
            int n;
            n = 0;
            set_req(0, 1'b1, OP_READ, 1);
            for (int i = 0; i < 20 && n < 8; i++) begin
                cycle();
                if (dut_grant == 0) begin
                    n++;
                    set_req(0, 1'b1, OP_READ, $urandom_range(0, 15));
                end
            end
            check("t4_reads", 64'(n), 64'(8));
        end
        cycle();
        check("t4_blocked", 64'(req_ready), 64'(0));
        check("t4_ren",     64'(ctl_ren),   64'(0));
        set_req(1, 1'b1, OP_WRITE, 5);
        cycle();
        check("t4_write", 64'(dut_grant), 64'(1));
        req_valid = '0;

        // In-order read return routing
        do_reset();
        ctl_ready = 1'b1; rsp_ready = '1;
        for (int i = 0; i < 3; i++) begin
            req_valid = '0;
            set_req(seq[i], 1'b1, OP_READ, 20 + i);
            cycle();
            check($sformatf("t5_issue%0d", i), 64'(dut_grant), 64'(seq[i]));
        end
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            logic [NR-1:0] ev;
            ev = '0; ev[seq[i]] = 1'b1;
            ctl_rdata = dat[i]; ctl_rdata_valid = 1'b1;
            #1;
            check($sformatf("t5_rspv%0d", i), 64'(rsp_valid), 64'(ev));
            check($sformatf("t5_data%0d", i), 64'(rsp_data),  dat[i]);
            cycle();
        end
        ctl_rdata_valid = 1'b0;

        // Orphan data, then reset in the middle of a stall
        do_reset();
        ctl_ready = 1'b1; rsp_ready = '1;
        ctl_rdata = 64'hDEAD; ctl_rdata_valid = 1'b1;
        cycle();
        ctl_rdata_valid = 1'b0;
        check("t6_orphan", 64'(err_orphan), 64'(1));
        set_req(0, 1'b1, OP_READ, 9);
        cycle();
        req_valid = '0; ctl_ready = 1'b0;
        set_req(1, 1'b1, OP_WRITE, 4);
        cycle();
        check("t6_pre_ren", 64'(ctl_ren), 64'(1));
        #3;
        power_on_rst_n = 1'b0;
        #1;
        check("t6_ctl_valid", 64'(ctl_valid),  64'(0));
        check("t6_ctl_cmd",   64'(ctl_cmd),    64'(0));
        check("t6_ctl_wdata", 64'(ctl_wdata),  64'(0));
        check("t6_ctl_ren",   64'(ctl_ren),    64'(0));
        check("t6_rsp_valid", 64'(rsp_valid),  64'(0));
        check("t6_err",       64'(err_orphan), 64'(0));
        check("t6_req_ready", 64'(req_ready),  64'(0));
        @(negedge clk);

        // Randomized traffic with a small row set so hits are frequent
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ctl_ready       = ($urandom_range(0, 9) < 7);
            rsp_ready       = NR'($urandom);
            ctl_rdata       = DATA_BITS'({$urandom, $urandom});
            ctl_rdata_valid = (tagq.size() > 0) && rsp_ready[tagq[0]] && ($urandom_range(0, 1) == 1);
            cycle();
            for (int k = 0; k < int'(NR); k++) begin
                if (dut_grant == k || !req_valid[k]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(k, 1'b1, ($urandom_range(0, 1) == 1) ? OP_READ : OP_WRITE,
                                $urandom_range(0, 3));
                    else
                        req_valid[k] = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frontend_cmd_arbiter.md
FRONTEND_CMD_ARBITER -- requirements
Module: frontend_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, giving the number of frontend requesters (2..4).
REQ-002 SHALL have parameter TAG_DEPTH, default 8, giving the number of outstanding reads tracked (power of 2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, giving the maximum number of consecutive row-hit grants that may bypass the round-robin winner.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-005 SHALL have port power_on_rst_n, input, 1 bit: reset, asynchronous, active-low; clock clk.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester command valid.
REQ-007 SHALL have port req_cmd, input, NUM_REQ x FRONTEND_CMD_BITS: per-requester frontend_command_t.
REQ-008 SHALL have port req_wdata, input, NUM_REQ x DQ_BITS*8: per-requester write data.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: acceptance pulse per requester.
REQ-010 SHALL have port ctl_valid, output, 1 bit: command valid to the bank-level controller.
REQ-011 SHALL have port ctl_cmd, output, FRONTEND_CMD_BITS: command to the controller.
REQ-012 SHALL have port ctl_wdata, output, DQ_BITS*8: write data to the controller.
REQ-013 SHALL have port ctl_ready, input, 1 bit: controller ba_cmd_pm (command accepted when ctl_valid and ctl_ready at a rising edge).
REQ-014 SHALL have port ctl_rdata, input, DQ_BITS*8: read data from the controller.
REQ-015 SHALL have port ctl_rdata_valid, input, 1 bit: read data valid.
REQ-016 SHALL have port ctl_ren, output, 1 bit: backend_controller_ren, read-return enable.
REQ-017 SHALL have port rsp_valid, output, NUM_REQ bits: read data valid routed per requester.
REQ-018 SHALL have port rsp_data, output, DQ_BITS*8: shared read data bus.
REQ-019 SHALL have port rsp_ready, input, NUM_REQ bits: requester able to take read data.
REQ-020 SHALL have port err_orphan, output, 1 bit: sticky flag for read data received with no outstanding tag.

Function
REQ-021 SHALL hold one output slot (ctl_valid/ctl_cmd/ctl_wdata, registered); cmd and wdata stay stable while ctl_valid=1 and ctl_ready=0.
REQ-022 SHALL treat the slot as loadable in a cycle when it is empty or when ctl_valid & ctl_ready hold in that cycle (back-to-back issue, 1 command/cycle).
REQ-023 SHALL make a requester eligible when req_valid=1, except that a read is ineligible while tag count = TAG_DEPTH.
REQ-024 SHALL grant as follows: among eligible requesters whose row_addr equals the last-issued row_addr (row hit), pick the first one starting at the RR pointer; if there is no hit, or the starve count = STARVE_LIMIT, pick the RR winner.
REQ-025 SHALL drive req_ready[k]=1 combinationally only when k is granted and the slot is loadable; that same edge loads the slot, and on a requester handshake the RR pointer advances to k+1 mod NUM_REQ.
REQ-026 SHALL update last-issued row on each slot load; after reset it is invalid, so no hit is possible.
REQ-027 SHALL increment the starve count when a hit grant differs from the RR winner, and clear it otherwise; it saturates at STARVE_LIMIT.
REQ-028 SHALL push the requester index into the tag FIFO on each read slot load; writes push nothing.
REQ-029 SHALL drive ctl_ren = tag FIFO not empty AND rsp_ready[head tag].
REQ-030 SHALL drive rsp_data = ctl_rdata and rsp_valid[head] = ctl_rdata_valid when the FIFO is non-empty; the FIFO pops on the same edge.
REQ-031 SHALL, on ctl_rdata_valid with an empty FIFO, drop the data and set err_orphan until reset.
REQ-032 SHALL allow a simultaneous push and pop in one cycle, leaving the count unchanged; a push when full cannot occur (REQ-023).

Reset
REQ-033 SHALL, while power_on_rst_n=0 (asynchronous, including mid-transfer), force ctl_valid=0, ctl_cmd=0, ctl_wdata=0, ctl_ren=0, rsp_valid=0, err_orphan=0, RR pointer=0, starve count=0, last row invalid, and tag FIFO empty; pending commands are discarded.

Structure
REQ-034 SHALL take frontend_command_t, OP_READ and OP_WRITE from frontend_command_definition_pkg, and SHALL add ARB_NUM_REQ, ARB_TAG_DEPTH and ARB_STARVE_LIMIT defaults there.
REQ-035 SHALL implement the tag FIFO as sub-module arb_tag_fifo (width clog2(NUM_REQ), depth TAG_DEPTH, count output).

Verification
REQ-036 SHALL test that requesters 0 and 1 each issuing a write with different rows, ctl_ready=1, produce grants 0,1,0,1 and ctl_valid high every cycle.
REQ-037 SHALL test that holding ctl_ready=0 for 5 cycles keeps ctl_cmd/ctl_wdata constant and req_ready=0 for all requesters.
REQ-038 SHALL test that, with requester 1 streaming row 3 and requester 0 on row 7 after a row-3 issue, requester 1 wins 4 times and requester 0 is then granted.
REQ-039 SHALL test that 8 reads from requester 0 with ctl_ren blocked by rsp_ready=0 make a 9th read ineligible, while a write from requester 1 still issues.
REQ-040 SHALL test that reads interleaved 0,1,0 return data 0xA,0xB,0xC routed to rsp_valid[0],[1],[0] in order.
REQ-041 SHALL test that ctl_rdata_valid with an empty FIFO sets err_orphan, and that reset asserted mid-stall clears all outputs within the same cycle.
